// File: rtl/sequence_memory_module_if.sv
// Command, generator handshake, playback and check signals of the sequence memory.
// The slave side is the sequence memory; the master side is the game controller/generator.
interface sequence_memory_module_if #(
   parameter int LEN_W = 6
);
   logic             i_clear;
   logic             i_append;
   logic             o_gen_req;
   logic             i_gen_valid;
   logic [2:0]       i_gen_value;
   logic             i_start_play;
   logic [3:0]       o_led;
   logic             o_play_busy;
   logic             o_play_done;
   logic             i_start_check;
   logic             i_check_valid;
   logic [2:0]       i_check_value;
   logic             o_match;
   logic             o_mismatch;
   logic             o_round_ok;
   logic [LEN_W-1:0] o_length;
   logic             o_full;

   modport slave (
      input  i_clear, i_append, i_gen_valid, i_gen_value, i_start_play,
      input  i_start_check, i_check_valid, i_check_value,
      output o_gen_req, o_led, o_play_busy, o_play_done,
      output o_match, o_mismatch, o_round_ok, o_length, o_full
   );

   modport master (
      output i_clear, i_append, i_gen_valid, i_gen_value, i_start_play,
      output i_start_check, i_check_valid, i_check_value,
      input  o_gen_req, o_led, o_play_busy, o_play_done,
      input  o_match, o_mismatch, o_round_ok, o_length, o_full
   );
endinterface

// File: rtl/sequence_memory_module.sv
// Colour sequence store: appends generated colours, replays them on one-hot LEDs
// with programmable on/off times, and checks player presses against the stored sequence.
//
// state      | meaning
// S_IDLE     | waiting for a command (clear > append > play > check)
// S_WAIT_GEN | generator requested, waiting for a legal colour
// S_PLAY_ON  | LED for element idx lit, ON_CYCLES long
// S_PLAY_OFF | LEDs dark, OFF_CYCLES long, then next element or done
// S_CHECK    | comparing player presses against element idx
module sequence_memory_module #(
   parameter int MAX_LEN    = 32,
   parameter int ON_CYCLES  = 50_000_000,
   parameter int OFF_CYCLES = 25_000_000,
   parameter int LEN_W      = $clog2(MAX_LEN + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   sequence_memory_module_if.slave bus
);

   localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_GEN,
      S_PLAY_ON,
      S_PLAY_OFF,
      S_CHECK
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       led_q, led_d;
   logic             busy_q, busy_d;
   logic             gen_req_q, gen_req_d;
   logic             done_q, done_d;
   logic             match_q, match_d;
   logic             mismatch_q, mismatch_d;
   logic             round_ok_q, round_ok_d;
   logic             full_q, full_d;

   logic [2:0]       mem_q [MAX_LEN];
   logic             mem_we;
   logic [IDX_W-1:0] mem_waddr;
   logic [2:0]       mem_wdata;

   logic [2:0]       cur_val;
   logic             idx_last;
   logic             gen_legal;

   function automatic logic [3:0] onehot(input logic [2:0] v);
      logic [3:0] r;
      case (v)
         3'd1:    r = 4'b0001;
         3'd2:    r = 4'b0010;
         3'd3:    r = 4'b0100;
         3'd4:    r = 4'b1000;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   assign cur_val   = mem_q[idx_q[IDX_W-1:0]];
   assign idx_last  = (idx_q == len_q - LEN_W'(1));
   assign gen_legal = (bus.i_gen_value >= 3'd1) && (bus.i_gen_value <= 3'd4);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      gen_req_d  = 1'b0;
      done_d     = 1'b0;
      match_d    = 1'b0;
      mismatch_d = 1'b0;
      round_ok_d = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = len_q[IDX_W-1:0];
      mem_wdata  = bus.i_gen_value;

      if (bus.i_clear) begin
         state_d = S_IDLE;
         len_d   = '0;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // A full-buffer append still consumes the cycle's command slot.
               if (bus.i_append) begin
                  if (!full_q) begin
                     state_d   = S_WAIT_GEN;
                     gen_req_d = 1'b1;
                  end
               end else if (bus.i_start_play) begin
                  if (len_q != '0) begin
                     state_d = S_PLAY_ON;
                     idx_d   = '0;
                     cnt_d   = '0;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if (bus.i_start_check) begin
                  if (len_q != '0) begin
                     state_d = S_CHECK;
                     idx_d   = '0;
                  end
               end
            end

            S_WAIT_GEN: begin
               if (bus.i_gen_valid && gen_legal) begin
                  mem_we  = 1'b1;
                  len_d   = len_q + LEN_W'(1);
                  state_d = S_IDLE;
               end
            end

            S_PLAY_ON: begin
               if (cnt_q == ON_LAST) begin
                  state_d = S_PLAY_OFF;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_PLAY_OFF: begin
               if (cnt_q == OFF_LAST) begin
                  cnt_d = '0;
                  if (idx_last) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_PLAY_ON;
                     idx_d   = idx_q + LEN_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end

            S_CHECK: begin
               if (bus.i_check_valid) begin
                  if (bus.i_check_value == cur_val) begin
                     if (idx_last) begin
                        round_ok_d = 1'b1;
                        state_d    = S_IDLE;
                     end else begin
                        match_d = 1'b1;
                        idx_d   = idx_q + LEN_W'(1);
                     end
                  end else begin
                     mismatch_d = 1'b1;
                     state_d    = S_IDLE;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end

      // LED follows the element the next cycle will show, so it stays registered.
      led_d  = (state_d == S_PLAY_ON) ? onehot(mem_q[idx_d[IDX_W-1:0]]) : 4'b0000;
      busy_d = (state_d == S_PLAY_ON) || (state_d == S_PLAY_OFF);
      full_d = (len_d == LEN_MAX);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q    <= S_IDLE;
         len_q      <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         led_q      <= '0;
         busy_q     <= 1'b0;
         gen_req_q  <= 1'b0;
         done_q     <= 1'b0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         round_ok_q <= 1'b0;
         full_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
         gen_req_q  <= gen_req_d;
         done_q     <= done_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         round_ok_q <= round_ok_d;
         full_q     <= full_d;
      end
   end

   // Sequence contents survive reset; only the length is cleared.
   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign bus.o_gen_req   = gen_req_q;
   assign bus.o_led       = led_q;
   assign bus.o_play_busy = busy_q;
   assign bus.o_play_done = done_q;
   assign bus.o_match     = match_q;
   assign bus.o_mismatch  = mismatch_q;
   assign bus.o_round_ok  = round_ok_q;
   assign bus.o_length    = len_q;
   assign bus.o_full      = full_q;

endmodule

// File: tb/tb_sequence_memory_module.sv
// Bench for sequence_memory_module: directed scenarios plus a random soak, all
// checked every cycle against a queue-based model of the game sequence.
module tb_sequence_memory_module;
   localparam int MAX_LEN = 4;
   localparam int ON      = 4;
   localparam int OFF     = 2;
   localparam int PER     = ON + OFF;
   localparam int LEN_W   = 3;

   localparam int M_IDLE  = 0;
   localparam int M_GEN   = 1;
   localparam int M_PLAY  = 2;
   localparam int M_CHECK = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sequence_memory_module_if #(.LEN_W(LEN_W)) bus();

   sequence_memory_module #(
      .MAX_LEN(MAX_LEN), .ON_CYCLES(ON), .OFF_CYCLES(OFF), .LEN_W(LEN_W)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus.slave)
   );

   int vectors = 0;
   int miscompares = 0;

   // reference model: sequence as a queue, playback as elapsed time
   int   seq[$];
   int   mode = M_IDLE;
   int   play_t = 0;
   int   chk_i = 0;
   logic [3:0] e_led = '0;
   logic e_busy = 0, e_done = 0, e_req = 0, e_match = 0, e_mis = 0, e_ok = 0;
   int   e_len = 0;
   bit   started = 0;

   always @(posedge clk) begin
      e_done = 0; e_req = 0; e_match = 0; e_mis = 0; e_ok = 0;
      if (!rst_n || bus.i_clear) begin
         mode = M_IDLE;
         seq.delete();
      end else begin
         case (mode)
            M_IDLE: begin
               if (bus.i_append) begin
                  if (seq.size() < MAX_LEN) begin mode = M_GEN; e_req = 1; end
               end else if (bus.i_start_play) begin
                  if (seq.size() > 0) begin mode = M_PLAY; play_t = 0; end
                  else e_done = 1;
               end else if (bus.i_start_check) begin
                  if (seq.size() > 0) begin mode = M_CHECK; chk_i = 0; end
               end
            end
            M_GEN: begin
               if (bus.i_gen_valid && bus.i_gen_value >= 1 && bus.i_gen_value <= 4) begin
                  seq.push_back(int'(bus.i_gen_value));
                  mode = M_IDLE;
               end
            end
            M_PLAY: begin
               play_t++;
               if (play_t == seq.size() * PER) begin mode = M_IDLE; e_done = 1; end
            end
            M_CHECK: begin
               if (bus.i_check_valid) begin
                  if (int'(bus.i_check_value) == seq[chk_i]) begin
                     if (chk_i == seq.size() - 1) begin e_ok = 1; mode = M_IDLE; end
                     else begin e_match = 1; chk_i++; end
                  end else begin
                     e_mis = 1;
                     mode = M_IDLE;
                  end
               end
            end
            default: mode = M_IDLE;
         endcase
      end
      e_busy = (mode == M_PLAY);
      e_led = '0;
      if (mode == M_PLAY && (play_t % PER) < ON) e_led = 4'(1 << (seq[play_t / PER] - 1));
      e_len = seq.size();
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         vectors++;
         if (bus.o_led !== e_led || bus.o_play_busy !== e_busy || bus.o_play_done !== e_done ||
             bus.o_gen_req !== e_req || bus.o_match !== e_match || bus.o_mismatch !== e_mis ||
             bus.o_round_ok !== e_ok || bus.o_length !== LEN_W'(e_len) ||
             bus.o_full !== (e_len == MAX_LEN)) begin
            miscompares++;
            $display("FAIL cycle_vector t=%0t got led=%b busy=%b done=%b req=%b m=%b mm=%b ok=%b len=%0d full=%b want led=%b busy=%b done=%b req=%b m=%b mm=%b ok=%b len=%0d full=%b",
               $time, bus.o_led, bus.o_play_busy, bus.o_play_done, bus.o_gen_req, bus.o_match,
               bus.o_mismatch, bus.o_round_ok, bus.o_length, bus.o_full,
               e_led, e_busy, e_done, e_req, e_match, e_mis, e_ok, e_len, (e_len == MAX_LEN));
         end
      end
   end

   // event counters from the DUT, for hand-computed expectations
   int req_cnt = 0, done_cnt = 0, match_cnt = 0, mis_cnt = 0, ok_cnt = 0, busy_cnt = 0;
   always @(negedge clk) begin
      if (bus.o_gen_req === 1'b1)   req_cnt++;
      if (bus.o_play_done === 1'b1) done_cnt++;
      if (bus.o_match === 1'b1)     match_cnt++;
      if (bus.o_mismatch === 1'b1)  mis_cnt++;
      if (bus.o_round_ok === 1'b1)  ok_cnt++;
      if (bus.o_play_busy === 1'b1) busy_cnt++;
   end

   // generator model answering o_gen_req
   int good_wait = 0, bad_wait = 0;
   bit inject_bad = 0, gen_rand = 0;
   int gen_vals[$];
   initial begin
      bus.i_gen_valid = 1'b0;
      bus.i_gen_value = 3'd0;
   end
   always @(negedge clk) begin
      bus.i_gen_valid = 1'b0;
      bus.i_gen_value = 3'd0;
      if (bus.o_gen_req === 1'b1) begin
         if (gen_rand) begin
            if ($urandom_range(0, 3) == 0) begin bad_wait = 1; good_wait = $urandom_range(2, 4); end
            else good_wait = $urandom_range(1, 3);
         end else if (inject_bad) begin
            bad_wait = 3; good_wait = 5; inject_bad = 0;
         end else begin
            good_wait = 3;
         end
      end
      if (bad_wait > 0) begin
         bad_wait--;
         if (bad_wait == 0) begin
            bus.i_gen_valid = 1'b1;
            bus.i_gen_value = gen_rand ? 3'($urandom_range(5, 8) % 8) : 3'd0;
         end
      end
      if (good_wait > 0) begin
         good_wait--;
         if (good_wait == 0) begin
            bus.i_gen_valid = 1'b1;
            bus.i_gen_value = (gen_vals.size() > 0) ? 3'(gen_vals.pop_front()) : 3'($urandom_range(1, 4));
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic zero_cmds();
      bus.i_clear = 0; bus.i_append = 0; bus.i_start_play = 0;
      bus.i_start_check = 0; bus.i_check_valid = 0; bus.i_check_value = 0;
   endtask

   task automatic append(input int val, input bit also_play, input bit bad);
      gen_vals.push_back(val);
      inject_bad = bad;
      bus.i_append = 1; bus.i_start_play = also_play;
      @(negedge clk);
      bus.i_append = 0; bus.i_start_play = 0;
      // a play request while waiting for the generator must be ignored
      bus.i_start_play = 1;
      @(negedge clk);
      bus.i_start_play = 0;
      repeat (6) @(negedge clk);
   endtask

   task automatic presses(input int n, input int v0, input int v1, input int v2, input int v3);
      int vals[4];
      vals = '{v0, v1, v2, v3};
      bus.i_start_check = 1;
      @(negedge clk);
      bus.i_start_check = 0;
      for (int i = 0; i < n; i++) begin
         bus.i_check_valid = 1; bus.i_check_value = 3'(vals[i]);
         @(negedge clk);
      end
      bus.i_check_valid = 0; bus.i_check_value = 0;
      repeat (2) @(negedge clk);
      #1;
   endtask

   logic [3:0] tr_led [30];
   int exp_led [24] = '{4,4,4,4,0,0, 1,1,1,1,0,0, 8,8,8,8,0,0, 2,2,2,2,0,0};

   initial begin
      int r_req, r_done, r_busy, r_match, r_mis, r_ok, done_at, busy_n;
      zero_cmds();
      rst_n = 0;
      @(negedge clk);
      repeat (3) begin
         bus.i_clear = 1'($urandom); bus.i_append = 1'($urandom); bus.i_start_play = 1'($urandom);
         bus.i_start_check = 1'($urandom); bus.i_check_valid = 1'($urandom);
         bus.i_check_value = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      chk("reset_length", int'(bus.o_length), 0);
      chk("reset_led", int'(bus.o_led), 0);
      zero_cmds();
      rst_n = 1;
      @(negedge clk);

      append(3, 0, 1);
      chk("len_after_1", int'(bus.o_length), 1);
      append(1, 1, 0);
      chk("len_after_2", int'(bus.o_length), 2);
      #1;
      chk("no_play_during_appends", done_cnt + busy_cnt, 0);
      @(negedge clk);
      append(4, 0, 0);
      append(2, 0, 0);
      chk("len_after_4", int'(bus.o_length), 4);
      chk("full_after_4", int'(bus.o_full), 1);

      r_req = req_cnt;
      bus.i_append = 1;
      @(negedge clk);
      bus.i_append = 0;
      repeat (4) @(negedge clk);
      #1;
      chk("append_when_full_req", req_cnt - r_req, 0);
      @(negedge clk);

      bus.i_start_play = 1;
      @(negedge clk);
      bus.i_start_play = 0;
      done_at = -1; busy_n = 0;
      for (int i = 0; i < 30; i++) begin
         tr_led[i] = bus.o_led;
         if (bus.o_play_busy === 1'b1) busy_n++;
         if (bus.o_play_done === 1'b1 && done_at < 0) done_at = i;
         @(negedge clk);
      end
      for (int i = 0; i < 24; i++) chk($sformatf("play_led[%0d]", i), int'(tr_led[i]), exp_led[i]);
      chk("play_busy_cycles", busy_n, 24);
      chk("play_done_cycle", done_at, 24);

      r_match = match_cnt; r_mis = mis_cnt; r_ok = ok_cnt;
      presses(4, 3, 1, 4, 2);
      chk("pass_match", match_cnt - r_match, 3);
      chk("pass_round_ok", ok_cnt - r_ok, 1);
      chk("pass_mismatch", mis_cnt - r_mis, 0);
      @(negedge clk);

      r_match = match_cnt; r_mis = mis_cnt; r_ok = ok_cnt;
      presses(2, 3, 2, 0, 0);
      chk("fail_match", match_cnt - r_match, 1);
      chk("fail_mismatch", mis_cnt - r_mis, 1);
      chk("fail_round_ok", ok_cnt - r_ok, 0);
      chk("fail_length", int'(bus.o_length), 4);
      @(negedge clk);

      r_done = done_cnt;
      bus.i_start_play = 1;
      @(negedge clk);
      bus.i_start_play = 0;
      repeat (7) @(negedge clk);
      chk("second_led_on", int'(bus.o_led), 1);
      bus.i_clear = 1;
      @(negedge clk);
      bus.i_clear = 0;
      chk("clear_led", int'(bus.o_led), 0);
      chk("clear_busy", int'(bus.o_play_busy), 0);
      r_busy = busy_cnt;
      repeat (30) @(negedge clk);
      #1;
      chk("clear_no_done", done_cnt - r_done, 0);
      chk("clear_no_busy", busy_cnt - r_busy, 0);
      chk("clear_length", int'(bus.o_length), 0);
      @(negedge clk);
      bus.i_start_play = 1;
      @(negedge clk);
      bus.i_start_play = 0;
      chk("empty_play_done", int'(bus.o_play_done), 1);
      chk("empty_play_led", int'(bus.o_led), 0);
      @(negedge clk);
      chk("empty_play_done_once", int'(bus.o_play_done), 0);

      gen_rand = 1;
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         bus.i_clear = ($urandom_range(0, 149) == 0);
         bus.i_append = ($urandom_range(0, 7) == 0);
         bus.i_start_play = ($urandom_range(0, 15) == 0);
         bus.i_start_check = ($urandom_range(0, 7) == 0);
         bus.i_check_valid = 1'($urandom);
         if (mode == M_CHECK && $urandom_range(0, 3) != 0) bus.i_check_value = 3'(seq[chk_i]);
         else bus.i_check_value = 3'($urandom_range(0, 7));
         @(negedge clk);
      end
      rst_n = 1;
      zero_cmds();
      repeat (40) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sequence_memory_module.md
# sequence_memory_module

Stores the game's colour sequence and drives both its playback and its checking. It sits directly downstream of the random generator. It requests one new colour (1–4) per round, appends it to an internal sequence buffer, and replays the whole buffer on one-hot LED outputs with programmable on/off times. It then compares player presses against the stored sequence, element by element, reporting match, mismatch and round-complete to the game controller.

## Interface
Parameters:
- MAX_LEN, 32: maximum sequence length (entries).
- ON_CYCLES, 50_000_000: cycles each LED is lit during playback (≥1).
- OFF_CYCLES, 25_000_000: dark cycles after each lit LED (≥1).
- LEN_W, $clog2(MAX_LEN+1): width of length/index values (6 at default).

Ports:
- i_clk  in  1  system clock; one clock, all logic on rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_clear  in  1  empty the sequence, abort any activity (new game).
- i_append  in  1  request one new element from the generator.
- o_gen_req  out  1  one-cycle trigger to generator.
- i_gen_valid  in  1  generator value valid (pulse).
- i_gen_value  in  3  generated colour, legal 1..4.
- i_start_play  in  1  start playback of whole sequence.
- o_led  out  4  one-hot playback LED (bit v-1 for colour v).
- o_play_busy  out  1  high in PLAY_ON/PLAY_OFF.
- o_play_done  out  1  one-cycle pulse, playback finished.
- i_start_check  in  1  enter check mode at index 0.
- i_check_valid  in  1  player press strobe.
- i_check_value  in  3  pressed colour, 1..4.
- o_match  out  1  pulse, press matched, more remain.
- o_mismatch  out  1  pulse, press wrong.
- o_round_ok  out  1  pulse, last element matched.
- o_length  out  LEN_W  stored element count.
- o_full  out  1  o_length == MAX_LEN.

## Operation
- Reset (i_rst_n=0 at an edge): state IDLE, length 0, all outputs 0. Memory contents are not reset.
- States: IDLE, WAIT_GEN, PLAY_ON, PLAY_OFF, CHECK.
- i_clear in any state (non-reset): length←0, IDLE, o_led←0, no pulses issued. Has priority over every other input.
- Commands are honoured only in IDLE. Priority is clear > append > play > check. Commands in other states are ignored.
- Append: if not full, IDLE→WAIT_GEN and o_gen_req=1 for one cycle. If full, the request is ignored (stay IDLE, no o_gen_req).
- WAIT_GEN: on i_gen_valid with value 1..4, mem[length]←value, length←length+1, →IDLE. An illegal value (0, 5–7) is discarded and the state stays WAIT_GEN. No timeout.
- Play with length>0: idx←0, →PLAY_ON.
  - PLAY_ON: o_led=onehot(mem[idx]) for ON_CYCLES, then →PLAY_OFF.
  - PLAY_OFF: o_led=0 for OFF_CYCLES. Then, if idx==length-1, o_play_done pulse and →IDLE; else idx+1 and →PLAY_ON.
- Play with length 0: o_play_done pulse next cycle, no LED activity.
- Check with length>0: idx←0, →CHECK. With length 0 the request is ignored.
- CHECK, per i_check_valid:
  - Value equals mem[idx] and idx==length-1: o_round_ok, →IDLE.
  - Value equals mem[idx] otherwise: o_match, idx+1.
  - Value differs (including illegal values): o_mismatch, →IDLE, length unchanged.
- Counters: the phase counter is wide enough for max(ON_CYCLES, OFF_CYCLES) and resets to 0 at every phase entry. idx never exceeds length-1.

## Timing
- All outputs are registered.
- o_gen_req is high in the cycle after i_append is sampled. i_gen_valid is accepted from that same cycle onward.
- o_length/o_full update in the cycle after i_gen_valid is accepted.
- Playback: i_start_play sampled at edge k. o_led is valid in cycles k+1 … k+ON_CYCLES, then 0 for OFF_CYCLES. The full play lasts length·(ON_CYCLES+OFF_CYCLES) cycles. o_play_done is high in the cycle immediately after the last OFF cycle. o_play_busy is high in exactly the LED-on and LED-off cycles.
- Check: o_match/o_mismatch/o_round_ok are high in the cycle after the i_check_valid sample. Back-to-back i_check_valid on consecutive cycles must work.
- At most one of o_match/o_mismatch/o_round_ok is high in any cycle.
- Reset or clear mid-play: o_led=0 and o_play_busy=0 from the next cycle, with no o_play_done.

## Test plan
Bench parameters: MAX_LEN=4, ON_CYCLES=4, OFF_CYCLES=2.
- Reset: hold i_rst_n=0 for 3 cycles with random inputs → all outputs 0, o_length=0.
- Append sequence: append values 3,1,4,2 via the generator model, with i_gen_valid 2 cycles after o_gen_req → o_length 1..4, o_full=1. A 5th i_append produces no o_gen_req. Injecting value 0 in WAIT_GEN leaves o_length unchanged.
- Playback: start play → o_led = 0100×4, 0000×2, 0001×4, 0000×2, 1000×4, 0000×2, 0010×4, 0000×2. o_play_done comes 1 cycle later, with o_play_busy high for exactly 24 cycles.
- Check pass/fail:
  - Presses 3,1,4,2 → o_match ×3 then o_round_ok.
  - Recheck with presses 3,2 → o_match then o_mismatch, state IDLE, o_length=4.
- Clear mid-play: i_clear during the 2nd LED-on phase → o_led=0 next cycle, no o_play_done, o_length=0. A following play gives o_play_done next cycle with no LED activity.
- Simultaneous: i_append and i_start_play in the same IDLE cycle → only o_gen_req fires. Play requests during WAIT_GEN are ignored.
